// File: rtl/rupt_priority_sched.sv
// RUPT priority scheduler: latches interrupt requests, arms the sequencer for entry at the
// next instruction boundary, tracks interrupt-in-progress until RESUME, and runs the RUPT LOCK watchdog.
module rupt_priority_sched #(
    parameter int NRUPT      = 10,
    parameter int VECW       = 4,
    parameter int LOCK_LIMIT = 140
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gojam,
    input  logic [NRUPT-1:0] rupt_req,
    input  logic             inhint,
    input  logic             ext_active,
    input  logic             inst_bnd,
    input  logic             rsm3,
    input  logic             tick,
    output logic             rptset,
    output logic             krpt,
    output logic [VECW-1:0]  rupt_vec,
    output logic             iip,
    output logic [NRUPT-1:0] pending,
    output logic             rptlock
);
    localparam int CW = $clog2(LOCK_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(LOCK_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ENTRY, S_SERVICE} state_t;

    state_t           r_state, w_state_next;
    logic [NRUPT-1:0] r_pending, w_clr, w_pending_next;
    logic [VECW-1:0]  r_vec, w_winner;
    logic [CW-1:0]    r_lock_cnt, r_idle_cnt, w_lock_next, w_idle_next;
    logic             r_rptlock;
    logic             w_iip, w_elig, w_latch;

    assign w_iip = (r_state == S_ENTRY) || (r_state == S_SERVICE);

    // krpt clears only the granted bit; a request in the same cycle re-sets it
    generate
        for (genvar gi = 0; gi < NRUPT; gi++) begin : g_clr
            assign w_clr[gi] = (r_state == S_ENTRY) && (r_vec == VECW'(gi));
        end
    endgenerate

    assign w_pending_next = (r_pending & ~w_clr) | rupt_req;
    assign w_elig         = (|r_pending) && !inhint && !ext_active && !w_iip;

    always_comb begin
        w_winner = '0;
        for (int i = NRUPT - 1; i >= 0; i--) begin
            if (r_pending[i]) w_winner = VECW'(i);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        case (r_state)
            S_IDLE:    if (w_elig) w_state_next = S_ARMED;
            S_ARMED: begin
                if (!w_elig) begin
                    w_state_next = S_IDLE;
                end else if (inst_bnd) begin
                    w_state_next = S_ENTRY;
                    w_latch      = 1'b1;
                end
            end
            S_ENTRY:   w_state_next = S_SERVICE;
            S_SERVICE: if (rsm3) w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Watchdog counters saturate at the limit so the alarm condition stays stable
    always_comb begin
        w_lock_next = r_lock_cnt;
        w_idle_next = r_idle_cnt;
        if (!w_iip) begin
            w_lock_next = '0;
        end else if (tick && (r_lock_cnt != LIMIT)) begin
            w_lock_next = r_lock_cnt + 1'b1;
        end
        if (r_state == S_ENTRY) begin
            w_idle_next = '0;
        end else if (!w_iip && tick && (r_idle_cnt != LIMIT)) begin
            w_idle_next = r_idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pending  <= '0;
            r_vec      <= '0;
            r_lock_cnt <= '0;
            r_idle_cnt <= '0;
            r_rptlock  <= 1'b0;
        end else if (gojam) begin
            r_state    <= S_IDLE;
            r_pending  <= '0;
            r_vec      <= '0;
            r_lock_cnt <= '0;
            r_idle_cnt <= '0;
            r_rptlock  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pending  <= w_pending_next;
            r_lock_cnt <= w_lock_next;
            r_idle_cnt <= w_idle_next;
            r_rptlock  <= r_rptlock || (w_lock_next == LIMIT) || (w_idle_next == LIMIT);
            if (w_latch) r_vec <= w_winner;
        end
    end

    assign rptset   = (r_state == S_ARMED);
    assign krpt     = (r_state == S_ENTRY);
    assign iip      = w_iip;
    assign rupt_vec = r_vec;
    assign pending  = r_pending;
    assign rptlock  = r_rptlock;
endmodule

// File: tb/tb_rupt_priority_sched.sv
// Bench for rupt_priority_sched: directed scenarios plus randomized traffic, every cycle
// compared against a flag-based behavioural model of the scheduler.
module tb_rupt_priority_sched;
    localparam int NR = 10;
    localparam int VW = 4;
    localparam int LL = 4;

    logic          clk = 1'b0;
    logic          rst, gojam, inhint, ext_active, inst_bnd, rsm3, tick;
    logic [NR-1:0] rupt_req;
    logic          rptset, krpt, iip, rptlock;
    logic [VW-1:0] rupt_vec;
    logic [NR-1:0] pending;

    int n_checks = 0;
    int n_errors = 0;

    // behavioural model state
    bit          m_armed, m_entering, m_serving, m_alarm;
    int          m_vec, m_lock, m_idle;
    bit [NR-1:0] m_pend;

    rupt_priority_sched #(.NRUPT(NR), .VECW(VW), .LOCK_LIMIT(LL)) dut (
        .clk(clk), .rst(rst), .gojam(gojam), .rupt_req(rupt_req), .inhint(inhint),
        .ext_active(ext_active), .inst_bnd(inst_bnd), .rsm3(rsm3), .tick(tick),
        .rptset(rptset), .krpt(krpt), .rupt_vec(rupt_vec), .iip(iip),
        .pending(pending), .rptlock(rptlock)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_armed = 0; m_entering = 0; m_serving = 0; m_alarm = 0;
        m_vec = 0; m_lock = 0; m_idle = 0; m_pend = '0;
    endtask

    task automatic model_step(input logic [NR-1:0] req, input bit inh, input bit ext,
                              input bit ib, input bit rs, input bit tk, input bit gj);
        bit busy, ok;
        int win;
        if (gj) begin
            model_reset();
            return;
        end
        busy = m_entering || m_serving;
        win = -1;
        for (int i = 0; i < NR; i++) if (m_pend[i] && win < 0) win = i;
        ok = (win >= 0) && !inh && !ext && !busy;
        if (m_entering) m_pend[m_vec] = 1'b0;
        m_pend = m_pend | req;
        if (busy) begin
            if (tk && m_lock < LL) m_lock++;
        end else begin
            m_lock = 0;
            if (tk && m_idle < LL) m_idle++;
        end
        if (m_entering) m_idle = 0;
        if (m_lock == LL || m_idle == LL) m_alarm = 1;
        if (m_entering) begin
            m_entering = 0;
            m_serving  = 1;
        end else if (m_serving) begin
            if (rs) m_serving = 0;
        end else if (m_armed) begin
            if (!ok) m_armed = 0;
            else if (ib) begin
                m_armed = 0; m_entering = 1; m_vec = win;
            end
        end else if (ok) begin
            m_armed = 1;
        end
    endtask

    task automatic compare_all();
        check("rptset",   32'(rptset),   32'(m_armed));
        check("krpt",     32'(krpt),     32'(m_entering));
        check("iip",      32'(iip),      32'(m_entering || m_serving));
        check("rupt_vec", 32'(rupt_vec), 32'(m_vec));
        check("pending",  32'(pending),  32'(m_pend));
        check("rptlock",  32'(rptlock),  32'(m_alarm));
    endtask

    task automatic cyc(input logic [NR-1:0] req, input logic inh, input logic ext,
                       input logic ib, input logic rs, input logic tk, input logic gj);
        rupt_req = req; inhint = inh; ext_active = ext;
        inst_bnd = ib; rsm3 = rs; tick = tk; gojam = gj;
        model_step(req, inh, ext, ib, rs, tk, gj);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle_cyc();
        cyc('0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int entries;
        rst = 1'b1; gojam = 0; rupt_req = '0; inhint = 0; ext_active = 0;
        inst_bnd = 0; rsm3 = 0; tick = 0;
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        check("reset_pending", 32'(pending), 32'h0);
        rst = 1'b0;

        // T1: single request, boundary three cycles after it
        cyc(10'(1 << 3), 0, 0, 0, 0, 0, 0);
        idle_cyc();
        check("t1_rptset", 32'(rptset), 32'h1);
        idle_cyc();
        cyc('0, 0, 0, 1, 0, 0, 0);
        check("t1_krpt", 32'(krpt), 32'h1);
        check("t1_vec", 32'(rupt_vec), 32'h3);
        idle_cyc();
        check("t1_pend", 32'(pending), 32'h0);
        check("t1_iip", 32'(iip), 32'h1);
        cyc('0, 0, 0, 0, 1, 0, 0);
        check("t1_iip_off", 32'(iip), 32'h0);
        check("t1_vec_hold", 32'(rupt_vec), 32'h3);
        $display("T1 entry vec=%0d", rupt_vec);

        // T2: simultaneous requests, priority then second entry
        cyc(10'((1 << 5) | (1 << 1)), 0, 0, 0, 0, 0, 0);
        idle_cyc();
        cyc('0, 0, 0, 1, 0, 0, 0);
        check("t2_vec1", 32'(rupt_vec), 32'h1);
        idle_cyc();
        check("t2_pend5", 32'(pending), 32'h20);
        cyc('0, 0, 0, 0, 1, 0, 0);
        idle_cyc();
        cyc('0, 0, 0, 1, 0, 0, 0);
        check("t2_vec5", 32'(rupt_vec), 32'h5);
        idle_cyc();
        cyc('0, 0, 0, 0, 1, 0, 0);
        $display("T2 second entry vec=%0d", rupt_vec);

        // T3: inhibited request survives boundaries
        cyc(10'h1, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            cyc('0, 1, 0, 1, 0, 0, 0);
            check("t3_rptset", 32'(rptset), 32'h0);
        end
        idle_cyc();
        cyc('0, 0, 0, 1, 0, 0, 0);
        check("t3_vec0", 32'(rupt_vec), 32'h0);
        check("t3_krpt", 32'(krpt), 32'h1);
        idle_cyc();
        cyc('0, 0, 0, 0, 1, 0, 0);
        $display("T3 entry vec=%0d", rupt_vec);

        // T4: EXTEND suppresses entry and disarms
        cyc(10'(1 << 7), 0, 0, 0, 0, 0, 0);
        idle_cyc();
        check("t4_armed", 32'(rptset), 32'h1);
        cyc('0, 0, 1, 1, 0, 0, 0);
        check("t4_no_krpt", 32'(krpt), 32'h0);
        check("t4_rptset_drop", 32'(rptset), 32'h0);
        idle_cyc();
        cyc('0, 0, 0, 1, 0, 0, 0);
        check("t4_vec7", 32'(rupt_vec), 32'h7);
        idle_cyc();
        cyc('0, 0, 0, 0, 1, 0, 0);
        $display("T4 entry vec=%0d", rupt_vec);

        // T5: watchdog alarm on held service
        cyc('0, 0, 0, 0, 0, 0, 1);
        check("t5_lock_clr", 32'(rptlock), 32'h0);
        cyc(10'(1 << 2), 0, 0, 0, 0, 0, 0);
        idle_cyc();
        cyc('0, 0, 0, 1, 0, 0, 0);
        idle_cyc();
        for (int k = 1; k <= LL; k++) begin
            cyc('0, 0, 0, 0, 0, 1, 0);
            check("t5_rptlock", 32'(rptlock), 32'(k == LL));
        end
        cyc('0, 0, 0, 0, 1, 0, 0);
        check("t5_sticky", 32'(rptlock), 32'h1);
        cyc('0, 0, 0, 0, 0, 0, 1);
        check("t5_gojam", 32'(rptlock), 32'h0);
        $display("T5 watchdog alarm and clear done");

        // T6: async reset in ENTRY with two pending sources
        cyc(10'h5, 0, 0, 0, 0, 0, 0);
        idle_cyc();
        cyc('0, 0, 0, 1, 0, 0, 0);
        check("t6_entry", 32'(krpt), 32'h1);
        check("t6_pre_pend", 32'(pending), 32'h5);
        #2 rst = 1'b1;
        #1;
        check("t6_pend", 32'(pending), 32'h0);
        check("t6_krpt", 32'(krpt), 32'h0);
        check("t6_iip", 32'(iip), 32'h0);
        check("t6_rptset", 32'(rptset), 32'h0);
        check("t6_vec", 32'(rupt_vec), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        compare_all();
        $display("T6 async reset done");

        // Randomized traffic against the model
        entries = 0;
        for (int n = 0; n < 2500; n++) begin
            logic [NR-1:0] rq;
            for (int b = 0; b < NR; b++) rq[b] = ($urandom_range(0, 15) == 0);
            cyc(rq, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
                $urandom_range(0, 7) == 0, $urandom_range(0, 149) == 0);
            if (krpt) entries++;
        end
        $display("RAND cycles=2500 entries=%0d", entries);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
